ascon_permutation_engine: RTL
=============================

ASCON_PERMUTATION_ENGINE -- requirements
Module: ascon_permutation_engine

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter UNROLL, default 1, meaning rounds computed per clock; legal values 1, 2, 3, 6.
REQ-003 Parameter PB_ROUNDS, default 6, meaning the round count of p_b; legal values 6, 8.
REQ-004 clock_i  in  1  system clock.
REQ-005 reset_i  in  1  synchronous active-high reset.
REQ-006 start_i  in  1  operation request, accepted only when ready_o=1.
REQ-007 ready_o  out  1  engine idle, can accept start_i.
REQ-008 mode_i  in  1  0 = p_a (12 rounds), 1 = p_b (PB_ROUNDS rounds).
REQ-009 load_i  in  1  1 = take state_i, 0 = continue from state_o.
REQ-010 state_i  in  type_state  external 320-bit state x0..x4.
REQ-011 key_i  in  128  key; data_i  in  64  data block.
REQ-012 etat_up_i  in  2  pre-XOR: 00 none; 01 x0^=data; 10 x0^=data and {x1,x2}^=key; 11 x4^=1.
REQ-013 etat_down_i  in  2  post-XOR: 00 none; 01 {x3,x4}^=key; 10 x4^=1; 11 none.
REQ-014 capture_cipher_i, capture_tag_i  in  1 each  capture requests sampled with start.
REQ-015 state_o  out  type_state  registered state.
REQ-016 cipher_o  out  64, cipher_valid_o  out  1  x0 after pre-XOR, sticky valid.
REQ-017 tag_o  out  128, tag_valid_o  out  1  {x3,x4} after post-XOR, sticky valid.
REQ-018 done_o  out  1  one-cycle completion pulse.

Function
REQ-019 FSM states SHALL be IDLE and RUN; ready_o=1 exactly in IDLE.
REQ-020 start_i with ready_o=1 SHALL latch mode, etat_down_i, capture flags and move to RUN; start_i in RUN SHALL be ignored.
REQ-021 All inputs except start_i, mode_i, load_i and the capture flags SHALL be held stable by the source until done_o.
REQ-022 Source = load_i ? state_i : state_o, sampled only on the accept edge.
REQ-023 Pre-XOR SHALL apply only on the first iteration, post-XOR only on the last.
REQ-024 Each iteration SHALL apply UNROLL rounds (p_C, p_S, p_L) and register the result in state_o.
REQ-025 Round index r SHALL count from 12-N to 11, N = round count; constant on x2 = ((15-r)<<4)|r.
REQ-026 Operation SHALL take N/UNROLL clock edges including the accept edge.
REQ-027 The FSM SHALL return to IDLE on the last edge, with done_o=1 for the following cycle.
REQ-028 Start SHALL be accepted in the done_o cycle (back-to-back), with zero bubble.
REQ-029 On the accept edge, cipher_o SHALL load x0 after pre-XOR and cipher_valid_o SHALL set, if capture_cipher_i=1.
REQ-030 On the last edge, tag_o SHALL load {x3,x4} after post-XOR and tag_valid_o SHALL set, if the tag flag is latched.
REQ-031 Valid flags SHALL clear only on reset or on a new accepted start, unless that start re-captures.
REQ-032 UNROLL not dividing both 12 and PB_ROUNDS SHALL be an elaboration error.

Reset
REQ-033 reset_i=1 at an edge SHALL force IDLE, state_o/cipher_o/tag_o=0, all valids and done_o=0, including mid-RUN (the operation is aborted, no done_o).
REQ-034 reset_i SHALL take priority over start_i in the same cycle.

Structure
REQ-035 type_state, round-constant function, mode and etat encodings SHALL live in ascon_pack.
REQ-036 One sub-module ascon_round (combinational p_C+p_S+p_L, round index input) SHALL be instantiated UNROLL times in a generate chain.

Verification
REQ-037 UNROLL=1, p_a, load, etat 00/00, start at cycle 0 -> done_o at cycle 12, state_o equals golden model.
REQ-038 Same vector, UNROLL=2 and UNROLL=3 -> identical state_o, done_o at cycles 6 and 4.
REQ-039 p_b with PB_ROUNDS=8, UNROLL=2, etat_up=01, data=0xFFFF_FFFF_FFFF_FFFF, capture cipher -> cipher_o = x0^data on cycle 1, done_o at cycle 4.
REQ-040 Back-to-back p_a then p_b with load_i=0 -> second start accepted in the done_o cycle, chained result equals model.
REQ-041 reset_i asserted at round 5 of p_a -> next cycle IDLE, outputs 0, no done_o; new start works.
REQ-042 start_i held high during RUN -> single operation, exactly one done_o pulse.

Source files
------------

// File: rtl/ascon_pack.sv
`default_nettype none
// ============================================================================
// Module      : ascon_pack (package)
// Description : Shared types and helpers for the Ascon permutation engine.
//               - type_state  : 320-bit state, index 0 = x0 ... index 4 = x4
//               - fsm_state_t : engine controller states
//               - mode / pre-XOR / post-XOR encodings
//               - round_const : round constant for a given round index
//               - rotr64      : 64-bit rotate right
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    localparam int c_pa_rounds = 12;

    // mode_i encoding
    localparam logic c_mode_pa = 1'b0;
    localparam logic c_mode_pb = 1'b1;

    // etat_up_i encoding (applied before the first round)
    localparam logic [1:0] c_up_none     = 2'b00;
    localparam logic [1:0] c_up_data     = 2'b01;
    localparam logic [1:0] c_up_data_key = 2'b10;
    localparam logic [1:0] c_up_dsep     = 2'b11;

    // etat_down_i encoding (applied after the last round)
    localparam logic [1:0] c_down_none   = 2'b00;
    localparam logic [1:0] c_down_key    = 2'b01;
    localparam logic [1:0] c_down_dsep   = 2'b10;
    localparam logic [1:0] c_down_rsvd   = 2'b11;

    // ((15 - r) << 4) | r for r in 0..11
    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'hf - r, r};
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_permutation_engine_round.sv
`default_nettype none
// ============================================================================
// Module      : ascon_round
// Description : One combinational Ascon round: constant addition (p_C),
//               bitsliced 5-bit S-box layer (p_S) and linear diffusion (p_L).
// Ports       : state_i  - state entering the round
//               round_i  - round index 0..11 selecting the constant
//               state_o  - state leaving the round
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
    logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;
    logic [63:0] w_s0, w_s1, w_s2, w_s3, w_s4;

    always_comb begin
        // p_C folded into the x2 input of the S-box
        w_a0 = state_i[0] ^ state_i[4];
        w_a1 = state_i[1];
        w_a2 = {state_i[2][63:8], state_i[2][7:0] ^ round_const(round_i)} ^ state_i[1];
        w_a3 = state_i[3];
        w_a4 = state_i[4] ^ state_i[3];

        // chi-like nonlinear core
        w_b0 = w_a0 ^ (~w_a1 & w_a2);
        w_b1 = w_a1 ^ (~w_a2 & w_a3);
        w_b2 = w_a2 ^ (~w_a3 & w_a4);
        w_b3 = w_a3 ^ (~w_a4 & w_a0);
        w_b4 = w_a4 ^ (~w_a0 & w_a1);

        // output mixing of the S-box
        w_s0 = w_b0 ^ w_b4;
        w_s1 = w_b1 ^ w_b0;
        w_s2 = ~w_b2;
        w_s3 = w_b3 ^ w_b2;
        w_s4 = w_b4;
    end

    assign state_o[0] = w_s0 ^ rotr64(w_s0, 19) ^ rotr64(w_s0, 28);
    assign state_o[1] = w_s1 ^ rotr64(w_s1, 61) ^ rotr64(w_s1, 39);
    assign state_o[2] = w_s2 ^ rotr64(w_s2,  1) ^ rotr64(w_s2,  6);
    assign state_o[3] = w_s3 ^ rotr64(w_s3, 10) ^ rotr64(w_s3, 17);
    assign state_o[4] = w_s4 ^ rotr64(w_s4,  7) ^ rotr64(w_s4, 41);

endmodule
`default_nettype wire

// File: rtl/ascon_permutation_engine.sv
`default_nettype none
// ============================================================================
// Module      : ascon_permutation_engine
// Description : Iterative Ascon permutation (p_a = 12 rounds, p_b =
//               PB_ROUNDS rounds) computing UNROLL rounds per clock, with
//               optional pre-XOR on the first iteration and post-XOR on the
//               last, plus cipher/tag capture registers.
// Ports       : clock_i, reset_i          - clock, sync active-high reset
//               start_i / ready_o         - request / idle handshake
//               mode_i, load_i            - p_a/p_b select, state source
//               state_i, key_i, data_i    - external state, key, data block
//               etat_up_i, etat_down_i    - pre-/post-XOR selects
//               capture_cipher_i/_tag_i   - capture requests
//               state_o                   - registered state
//               cipher_o/_valid_o         - x0 after pre-XOR, sticky valid
//               tag_o/_valid_o            - {x3,x4} after post-XOR, sticky
//               done_o                    - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_permutation_engine
    import ascon_pack::*;
#(
    parameter int UNROLL    = 1,
    parameter int PB_ROUNDS = 6
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    output logic         ready_o,
    input  logic         mode_i,
    input  logic         load_i,
    input  type_state    state_i,
    input  logic [127:0] key_i,
    input  logic [63:0]  data_i,
    input  logic [1:0]   etat_up_i,
    input  logic [1:0]   etat_down_i,
    input  logic         capture_cipher_i,
    input  logic         capture_tag_i,
    output type_state    state_o,
    output logic [63:0]  cipher_o,
    output logic         cipher_valid_o,
    output logic [127:0] tag_o,
    output logic         tag_valid_o,
    output logic         done_o
);

    generate
        if ((UNROLL != 1 && UNROLL != 2 && UNROLL != 3 && UNROLL != 6) ||
            (PB_ROUNDS != 6 && PB_ROUNDS != 8) ||
            (c_pa_rounds % UNROLL != 0) || (PB_ROUNDS % UNROLL != 0)) begin : g_param_check
            $error("ascon_permutation_engine: UNROLL must divide both 12 and PB_ROUNDS");
        end
    endgenerate

    localparam logic [3:0] c_unroll    = 4'(UNROLL);
    localparam logic [3:0] c_pa_steps  = 4'(c_pa_rounds / UNROLL);
    localparam logic [3:0] c_pb_steps  = 4'(PB_ROUNDS / UNROLL);
    localparam logic [3:0] c_pb_first  = 4'(c_pa_rounds - PB_ROUNDS);

    fsm_state_t   r_fsm, w_fsm_next;
    logic         r_mode;
    logic [1:0]   r_down;
    logic         r_cap_tag;
    logic [3:0]   r_iter;
    type_state    r_state;
    logic [63:0]  r_cipher;
    logic         r_cipher_valid;
    logic [127:0] r_tag;
    logic         r_tag_valid;
    logic         r_done;

    logic         w_accept, w_busy, w_last;
    logic         w_mode, w_cap_tag;
    logic [1:0]   w_down;
    logic [3:0]   w_iter, w_steps, w_round_base;
    type_state    w_src, w_pre, w_round_in, w_round_out, w_post;

    // On the accept edge the first iteration is already computed, so the
    // latched controls are bypassed by the live inputs during that cycle.
    assign w_accept     = (r_fsm == IDLE) && start_i;
    assign w_busy       = w_accept || (r_fsm == RUN);
    assign w_mode       = w_accept ? mode_i        : r_mode;
    assign w_down       = w_accept ? etat_down_i   : r_down;
    assign w_cap_tag    = w_accept ? capture_tag_i : r_cap_tag;
    assign w_iter       = w_accept ? 4'd0          : r_iter;
    assign w_steps      = (w_mode == c_mode_pa) ? c_pa_steps : c_pb_steps;
    assign w_last       = (w_iter == w_steps - 4'd1);
    assign w_round_base = ((w_mode == c_mode_pb) ? c_pb_first : 4'd0) + w_iter * c_unroll;

    always_comb begin
        w_src = load_i ? state_i : r_state;
        w_pre = w_src;
        case (etat_up_i)
            c_up_none: ;
            c_up_data: w_pre[0] = w_src[0] ^ data_i;
            c_up_data_key: begin
                w_pre[0] = w_src[0] ^ data_i;
                w_pre[1] = w_src[1] ^ key_i[127:64];
                w_pre[2] = w_src[2] ^ key_i[63:0];
            end
            c_up_dsep: w_pre[4] = w_src[4] ^ 64'd1;
            default: ;
        endcase
    end

    assign w_round_in = w_accept ? w_pre : r_state;

    // Round chain: stage k uses round index base + k
    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        type_state w_in, w_out;
        if (k == 0) begin : g_head
            assign w_in = w_round_in;
        end else begin : g_link
            assign w_in = g_round[k-1].w_out;
        end
        ascon_round u_round (
            .state_i (w_in),
            .round_i (w_round_base + 4'(k)),
            .state_o (w_out)
        );
    end

    assign w_round_out = g_round[UNROLL-1].w_out;

    always_comb begin
        w_post = w_round_out;
        if (w_last) begin
            case (w_down)
                c_down_none: ;
                c_down_key: begin
                    w_post[3] = w_round_out[3] ^ key_i[127:64];
                    w_post[4] = w_round_out[4] ^ key_i[63:0];
                end
                c_down_dsep: w_post[4] = w_round_out[4] ^ 64'd1;
                c_down_rsvd: ;
                default: ;
            endcase
        end
    end

    // Controller
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE: if (start_i && !w_last) w_fsm_next = RUN;
            RUN:  if (w_last)             w_fsm_next = IDLE;
            default: w_fsm_next = IDLE;
        endcase
    end

    // Datapath and capture registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_mode         <= 1'b0;
            r_down         <= 2'b00;
            r_cap_tag      <= 1'b0;
            r_iter         <= 4'd0;
            r_state        <= '0;
            r_cipher       <= '0;
            r_cipher_valid <= 1'b0;
            r_tag          <= '0;
            r_tag_valid    <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= w_busy && w_last;
            if (w_busy) begin
                r_state <= w_post;
                r_iter  <= w_iter + 4'd1;
            end
            if (w_accept) begin
                r_mode         <= mode_i;
                r_down         <= etat_down_i;
                r_cap_tag      <= capture_tag_i;
                r_cipher_valid <= capture_cipher_i;
                if (capture_cipher_i) begin
                    r_cipher <= w_pre[0];
                end
                if (!capture_tag_i) begin
                    r_tag_valid <= 1'b0;
                end
            end
            // Later assignment wins when accept and last coincide
            if (w_busy && w_last && w_cap_tag) begin
                r_tag       <= {w_post[3], w_post[4]};
                r_tag_valid <= 1'b1;
            end
        end
    end

    assign ready_o        = (r_fsm == IDLE);
    assign state_o        = r_state;
    assign cipher_o       = r_cipher;
    assign cipher_valid_o = r_cipher_valid;
    assign tag_o          = r_tag;
    assign tag_valid_o    = r_tag_valid;
    assign done_o         = r_done;

endmodule
`default_nettype wire
